bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_bus_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: a byte FIFO fed from the core bus,
// drained by an 8N1 serialiser, with a registered status readback.
module bus_uart_tx #(
   parameter logic [31:0] BASE    = 32'h10000000,
   parameter int          CLK_DIV = 16,
   parameter int          DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wren,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] rdata,
   output logic        uart_tx
);

   localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] STATUS_ADDR = BASE + 32'd4;
   localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
   localparam logic [AW:0] FULL_COUNT  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state;
   logic [15:0]   r_bitCnt;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic [7:0]    r_fifo [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [31:0]   r_addr;

   logic w_push;
   logic w_clear;
   logic w_full;
   logic w_empty;
   logic w_busy;
   logic w_bitDone;
   logic w_pop;
   logic w_accept;
   logic w_ovfEvent;
   logic w_unused;

   assign w_push     = mem_wren && mem_wmask[0] && (mem_addr == BASE);
   assign w_clear    = mem_wren && mem_wmask[0] && (mem_addr == STATUS_ADDR) && mem_wdata[2];
   assign w_full     = (r_count == FULL_COUNT);
   assign w_empty    = (r_count == '0);
   assign w_busy     = (r_state != IDLE) || !w_empty;
   assign w_bitDone  = (r_bitCnt == 16'd0);
   assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bitDone));
   assign w_accept   = w_push && (!w_full || w_pop);
   assign w_ovfEvent = w_push && w_full && !w_pop;
   assign w_unused   = &{1'b0, mem_wdata[31:8], mem_wmask[3:1]};

   // FIFO storage; a pop in the same cycle frees the slot a full-FIFO push lands in
   always_ff @(posedge clk) begin
      if (!rst && w_accept) begin
         r_fifo[r_wrPtr] <= mem_wdata[7:0];
      end
   end

   // FIFO pointers wrap naturally at DEPTH; count tracks push/pop balance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Serialiser FSM: start bit, 8 data bits LSB first, stop bit, back-to-back when more data waits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_bitCnt <= 16'd0;
         r_bitIdx <= 3'd0;
         r_shift  <= 8'd0;
         uart_tx  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state  <= START;
                  r_shift  <= r_fifo[r_rdPtr];
                  r_bitCnt <= BIT_RELOAD;
                  uart_tx  <= 1'b0;
               end
            end
            START: begin
               if (w_bitDone) begin
                  r_state  <= DATA;
                  r_bitIdx <= 3'd0;
                  uart_tx  <= r_shift[0];
                  r_shift  <= r_shift >> 1;
                  r_bitCnt <= BIT_RELOAD;
               end else begin
                  r_bitCnt <= r_bitCnt - 16'd1;
               end
            end
            DATA: begin
               if (w_bitDone) begin
                  r_bitCnt <= BIT_RELOAD;
                  if (r_bitIdx == 3'd7) begin
                     r_state <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     r_bitIdx <= r_bitIdx + 3'd1;
                     uart_tx  <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                  end
               end else begin
                  r_bitCnt <= r_bitCnt - 16'd1;
               end
            end
            STOP: begin
               if (w_bitDone) begin
                  if (w_pop) begin
                     r_state  <= START;
                     r_shift  <= r_fifo[r_rdPtr];
                     r_bitCnt <= BIT_RELOAD;
                     uart_tx  <= 1'b0;
                  end else begin
                     r_state  <= IDLE;
                     r_bitCnt <= 16'd0;
                     uart_tx  <= 1'b1;
                  end
               end else begin
                  r_bitCnt <= r_bitCnt - 16'd1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_bitCnt <= 16'd0;
               uart_tx  <= 1'b1;
            end
         endcase
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovfEvent) begin
         r_ovf <= 1'b1;
      end else if (w_clear) begin
         r_ovf <= 1'b0;
      end
   end

   // Read path mirrors main memory: address is registered, then data is registered from it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= 32'd0;
         rdata  <= 32'd0;
      end else begin
         r_addr <= mem_addr;
         rdata  <= (r_addr == STATUS_ADDR) ? {29'b0, r_ovf, w_full, w_busy} : 32'd0;
      end
   end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed scenarios plus a random phase,
// every cycle compared against a frame-timing reference model.
module tb_bus_uart_tx;

   localparam int          CLK_DIV = 4;
   localparam int          DEPTH   = 8;
   localparam int          FRAME   = 10 * CLK_DIV;
   localparam logic [31:0] BASE    = 32'h10000000;
   localparam logic [31:0] STATUS  = BASE + 32'd4;
   localparam logic [31:0] TOHOST  = 32'h10001000;

   logic        clock;
   logic        rst;
   logic        memWren;
   logic [3:0]  memWmask;
   logic [31:0] memWdata;
   logic [31:0] memAddr;
   logic [31:0] rdata;
   logic        uartTx;

   int total;
   int passed;

   // Reference model: a byte queue plus the edge index at which the current frame began
   logic [7:0]  mq[$];
   int          mt;
   bit          mActive;
   int          mFrameStart;
   logic [7:0]  mByte;
   bit          mOvf;
   logic        mTx;
   logic [31:0] mAddrReg;
   logic [31:0] mRdata;

   bus_uart_tx #(
      .BASE    (BASE),
      .CLK_DIV (CLK_DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clock),
      .rst       (rst),
      .mem_wren  (memWren),
      .mem_wmask (memWmask),
      .mem_wdata (memWdata),
      .mem_addr  (memAddr),
      .rdata     (rdata),
      .uart_tx   (uartTx)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
   endtask

   // Advance the model by one clock edge using the inputs held across that edge
   task automatic modelEdge();
      logic [31:0] statusNow;
      bit          pop;
      bit          wrData;
      bit          wrClr;
      bit          ovfEv;
      int          k;
      statusNow = {29'b0, mOvf, (mq.size() == DEPTH), (mActive || (mq.size() > 0))};
      if (rst) begin
         mq.delete();
         mActive  = 0;
         mOvf     = 0;
         mRdata   = 32'd0;
         mAddrReg = 32'd0;
         mTx      = 1'b1;
         mt++;
         return;
      end
      mRdata   = (mAddrReg == STATUS) ? statusNow : 32'd0;
      mAddrReg = memAddr;
      pop = 0;
      if (mActive) begin
         if (mt - mFrameStart == FRAME) begin
            if (mq.size() > 0) pop = 1;
            else mActive = 0;
         end
      end else if (mq.size() > 0) begin
         pop = 1;
      end
      wrData = memWren && memWmask[0] && (memAddr == BASE);
      wrClr  = memWren && memWmask[0] && (memAddr == STATUS) && memWdata[2];
      ovfEv  = 0;
      if (pop) begin
         mByte       = mq.pop_front();
         mActive     = 1;
         mFrameStart = mt;
      end
      if (wrData) begin
         if (mq.size() < DEPTH) mq.push_back(memWdata[7:0]);
         else ovfEv = 1;
      end
      if (ovfEv) mOvf = 1;
      else if (wrClr) mOvf = 0;
      if (mActive) begin
         k = (mt - mFrameStart) / CLK_DIV;
         if (k == 0) mTx = 1'b0;
         else if (k <= 8) mTx = mByte[k-1];
         else mTx = 1'b1;
      end else begin
         mTx = 1'b1;
      end
      mt++;
   endtask

   function automatic bit popNext();
      return mActive && (mt - mFrameStart == FRAME) && (mq.size() > 0);
   endfunction

   task automatic applyStimulus(input bit wren, input logic [3:0] wmask, input logic [31:0] addr, input logic [31:0] wdata);
      memWren  = wren;
      memWmask = wmask;
      memAddr  = addr;
      memWdata = wdata;
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput("uart_tx", {31'b0, uartTx}, {31'b0, mTx});
      checkOutput("rdata", rdata, mRdata);
   endtask

   task automatic idle(input int n, input logic [31:0] addr);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, addr, 32'd0);
   endtask

   initial begin
      int waited;
      int r;
      total       = 0;
      passed      = 0;
      mt          = 0;
      mActive     = 0;
      mFrameStart = 0;
      mByte       = 8'd0;
      mOvf        = 0;
      mTx         = 1'b1;
      mAddrReg    = 32'd0;
      mRdata      = 32'd0;
      rst         = 1'b1;

      // Reset: line idles high, readback zero, a write during reset is ignored
      idle(2, STATUS);
      applyStimulus(1'b1, 4'h1, BASE, 32'h000000A5);
      checkOutput("reset_tx", {31'b0, uartTx}, 32'd1);
      checkOutput("reset_rdata", rdata, 32'd0);
      rst = 1'b0;
      idle(3, STATUS);
      checkOutput("post_reset_status", rdata, 32'd0);

      // Read timing: BASE reads as zero
      idle(2, BASE);
      checkOutput("rdata_base", rdata, 32'd0);

      // Single byte 0x55: start bit one cycle after the write edge, idle again after a frame
      applyStimulus(1'b1, 4'h1, BASE, 32'h00000055);
      applyStimulus(1'b0, 4'h0, STATUS, 32'd0);
      checkOutput("single_start_bit", {31'b0, uartTx}, 32'd0);
      idle(1, STATUS);
      checkOutput("single_busy", rdata, 32'd1);
      idle(43, STATUS);
      checkOutput("single_idle", rdata, 32'd0);

      // Back-to-back frames with no idle gap between stop and next start
      applyStimulus(1'b1, 4'h1, BASE, 32'h00000041);
      applyStimulus(1'b1, 4'h1, BASE, 32'h00000042);
      applyStimulus(1'b1, 4'h1, BASE, 32'h00000043);
      idle(38, STATUS);
      checkOutput("b2b_last_stop", {31'b0, uartTx}, 32'd1);
      idle(1, STATUS);
      checkOutput("b2b_second_start", {31'b0, uartTx}, 32'd0);
      idle(90, STATUS);
      checkOutput("b2b_done", rdata, 32'd0);

      // Overflow: ten writes in ten cycles, nine accepted, flag sticky until cleared
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'h1, BASE, $urandom);
      idle(2, STATUS);
      checkOutput("ovf_status", rdata, 32'd7);
      applyStimulus(1'b1, 4'h1, STATUS, 32'd4);
      idle(2, STATUS);
      checkOutput("ovf_cleared", rdata, 32'd3);
      idle(9 * FRAME, STATUS);
      checkOutput("ovf_drained", rdata, 32'd0);

      // Full FIFO plus push on the exact STOP->START pop edge
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'h1, BASE, $urandom);
      waited = 0;
      while (!popNext() && waited < 100) begin
         applyStimulus(1'b0, 4'h0, STATUS, 32'd0);
         waited++;
      end
      checkOutput("fullpop_wait_bound", {31'b0, popNext()}, 32'd1);
      checkOutput("fullpop_full_before", rdata, 32'd3);
      applyStimulus(1'b1, 4'h1, BASE, 32'h0000005A);
      idle(2, STATUS);
      checkOutput("fullpop_no_ovf", rdata, 32'd3);
      idle(9 * FRAME + 10, STATUS);
      checkOutput("fullpop_drained", rdata, 32'd0);

      // Writes that must be ignored: mask lane 0 clear, tohost, other address
      applyStimulus(1'b1, 4'hE, BASE, 32'h00000011);
      applyStimulus(1'b1, 4'hF, TOHOST, 32'h00000022);
      applyStimulus(1'b1, 4'hF, BASE + 32'd8, 32'h00000033);
      idle(3, STATUS);
      checkOutput("ignored_writes", rdata, 32'd0);

      // Reset in the middle of data bit 3 aborts the frame
      applyStimulus(1'b1, 4'h1, BASE, 32'h000000F0);
      applyStimulus(1'b1, 4'h1, BASE, 32'h0000000F);
      idle(17, STATUS);
      rst = 1'b1;
      applyStimulus(1'b1, 4'h1, BASE, 32'h00000099);
      rst = 1'b0;
      checkOutput("midreset_tx", {31'b0, uartTx}, 32'd1);
      idle(2, STATUS);
      checkOutput("midreset_status", rdata, 32'd0);
      applyStimulus(1'b1, 4'h1, BASE, $urandom);
      idle(FRAME + 4, STATUS);
      checkOutput("midreset_clean_frame", rdata, 32'd0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 15);
         case (r)
            0, 1:    applyStimulus(1'b1, 4'h1, BASE, $urandom);
            2:       applyStimulus(1'b1, 4'($urandom), BASE, $urandom);
            3:       applyStimulus(1'b1, 4'h1, STATUS, $urandom);
            4:       applyStimulus(1'b1, 4'hF, TOHOST, $urandom);
            default: applyStimulus(1'b0, 4'h0, ($urandom_range(0, 1) == 0) ? BASE : STATUS, 32'd0);
         endcase
      end
      idle((DEPTH + 2) * FRAME, STATUS);
      checkOutput("random_drained_busy", {31'b0, rdata[0]}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
